// File: rtl/core_pkg.sv
// Shared core definitions: fetch FSM states, word sizes, reset/offset defaults.
package core_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned INSTR_BYTES = 4;

    // Shared with decode and the register file so all stages agree on the PC view.
    localparam logic [WORD_W-1:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [WORD_W-1:0] DEFAULT_PC_OFFSET = 32'd8;

    localparam logic [WORD_W-1:0] PC_INC = WORD_W'(INSTR_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        BLOCKED,
        FLUSH
    } fetch_state_t;

    // One fetched instruction together with its architectural PC.
    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
    } fetch_word_t;

endpackage

// File: rtl/fetch_skid.sv
// OUT register plus one-entry skid buffer between instruction memory and decode.
module fetch_skid
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        load_i,
    input  fetch_word_t word_i,
    input  logic        stall_i,
    output fetch_word_t out_o,
    output logic        valid_o,
    output logic        to_skb_o,
    output logic        drain_o
);

    fetch_word_t out_q, out_d;
    fetch_word_t skb_q, skb_d;
    logic        out_valid_q, out_valid_d;
    logic        skb_full_q, skb_full_d;
    logic        consume;

    assign consume  = out_valid_q && !stall_i;
    assign to_skb_o = load_i && !flush_i && out_valid_q && !consume && !skb_full_q;
    assign drain_o  = !flush_i && consume && skb_full_q;
    assign out_o    = out_q;
    assign valid_o  = out_valid_q;

    // Next-state for OUT/SKB: flush beats SKB drain, which beats new memory data.
    always_comb begin
        out_d       = out_q;
        skb_d       = skb_q;
        out_valid_d = out_valid_q;
        skb_full_d  = skb_full_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
            skb_full_d  = 1'b0;
        end else if (consume && skb_full_q) begin
            out_d       = skb_q;
            out_valid_d = 1'b1;
            skb_full_d  = 1'b0;
        end else if (load_i) begin
            if (!out_valid_q || consume) begin
                out_d       = word_i;
                out_valid_d = 1'b1;
            end else begin
                skb_d      = word_i;
                skb_full_d = 1'b1;
            end
        end else if (consume) begin
            out_valid_d = 1'b0;
        end
    end

    // Buffer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_q       <= '0;
            skb_q       <= '0;
            out_valid_q <= 1'b0;
            skb_full_q  <= 1'b0;
        end else begin
            out_q       <= out_d;
            skb_q       <= skb_d;
            out_valid_q <= out_valid_d;
            skb_full_q  <= skb_full_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues imem reads, redirects on branches.
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [WORD_W-1:0] PC_OFFSET = DEFAULT_PC_OFFSET
) (
    input  logic              clk,
    input  logic              rst,
    output logic              o_imem_req,
    output logic [WORD_W-1:0] o_imem_addr,
    input  logic              i_imem_ack,
    input  logic [WORD_W-1:0] i_imem_data,
    input  logic              i_stall,
    input  logic              i_branch_en,
    input  logic [WORD_W-1:0] i_branch_target,
    output logic [WORD_W-1:0] o_instr,
    output logic              o_instr_valid,
    output logic [WORD_W-1:0] o_pc
);

    fetch_state_t      state_q, state_d;
    logic [WORD_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [WORD_W-1:0] pend_q, pend_d;

    logic              xfer;
    logic              load;
    logic              to_skb;
    logic              drain;
    logic [WORD_W-1:0] target;
    logic              target_lsb_unused;
    fetch_word_t       in_word;
    fetch_word_t       out_word;

    assign target            = {i_branch_target[WORD_W-1:2], 2'b00};
    assign target_lsb_unused = ^i_branch_target[1:0];

    // req is a pure decode of the state register, so it stays registered.
    assign o_imem_req  = (state_q == FETCH) || (state_q == FLUSH);
    assign o_imem_addr = fetch_pc_q;

    assign xfer          = o_imem_req && i_imem_ack;
    assign load          = xfer && (state_q == FETCH) && !i_branch_en;
    assign in_word.instr = i_imem_data;
    assign in_word.pc    = fetch_pc_q + PC_OFFSET;

    fetch_skid u_skid (
        .clk      (clk),
        .rst      (rst),
        .flush_i  (i_branch_en),
        .load_i   (load),
        .word_i   (in_word),
        .stall_i  (i_stall),
        .out_o    (out_word),
        .valid_o  (o_instr_valid),
        .to_skb_o (to_skb),
        .drain_o  (drain)
    );

    assign o_instr = out_word.instr;
    assign o_pc    = out_word.pc;

    // FSM next-state and fetch address selection; branch has top priority.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pend_d     = pend_q;
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (i_branch_en) fetch_pc_d = target;
            end
            FETCH: begin
                if (i_branch_en) begin
                    if (!i_imem_ack) begin
                        state_d = FLUSH;
                        pend_d  = target;
                    end else begin
                        fetch_pc_d = target;
                    end
                end else if (xfer) begin
                    fetch_pc_d = fetch_pc_q + PC_INC;
                    if (to_skb) state_d = BLOCKED;
                end
            end
            BLOCKED: begin
                if (i_branch_en) begin
                    state_d    = FETCH;
                    fetch_pc_d = target;
                end else if (drain) begin
                    state_d = FETCH;
                end
            end
            FLUSH: begin
                if (i_imem_ack) begin
                    state_d    = FETCH;
                    fetch_pc_d = i_branch_en ? target : pend_q;
                end else if (i_branch_en) begin
                    pend_d = target;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, fetch address and pending branch target registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            pend_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pend_q     <= pend_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus, negedge monitor.
module tb_fetch_unit;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_data;
    logic        i_stall;
    logic        i_branch_en;
    logic [31:0] i_branch_target;
    logic [31:0] o_instr;
    logic        o_instr_valid;
    logic [31:0] o_pc;

    always #5 clk = ~clk;

    // Memory returns its own address as data.
    assign i_imem_data = o_imem_addr;

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .PC_OFFSET (32'd8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .o_imem_req      (o_imem_req),
        .o_imem_addr     (o_imem_addr),
        .i_imem_ack      (i_imem_ack),
        .i_imem_data     (i_imem_data),
        .i_stall         (i_stall),
        .i_branch_en     (i_branch_en),
        .i_branch_target (i_branch_target),
        .o_instr         (o_instr),
        .o_instr_valid   (o_instr_valid),
        .o_pc            (o_pc)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned tests  = 0;
    int unsigned failed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},   {31'b0, o_imem_req},    32'h0);
        chk({tag, "_addr"},  o_imem_addr,            32'h0);
        chk({tag, "_valid"}, {31'b0, o_instr_valid}, 32'h0);
        chk({tag, "_instr"}, o_instr,                32'h0);
        chk({tag, "_pc"},    o_pc,                   32'h0);
    endtask

    // Monitor: every consumed output word must match the next expected entry.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (o_instr_valid === 1'b1 && i_stall === 1'b0) begin
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_out: got instr %h pc %h, expected none", o_instr, o_pc);
            end else begin
                e = exp_q.pop_front();
                chk("out_instr", o_instr, e.instr);
                chk("out_pc",    o_pc,    e.pc);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst             = 1'b0;
        i_imem_ack      = 1'b0;
        i_stall         = 1'b0;
        i_branch_en     = 1'b0;
        i_branch_target = 32'h0;

        // Stream (with a stall in the middle) delivers words 0..32 in order.
        for (int unsigned a = 0; a <= 32; a += 4) push(a, a + 8);

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk_reset_outputs("reset");
        end
        rst        = 1'b1;
        i_imem_ack = 1'b1;

        tick(1);
        chk("startup_req",  {31'b0, o_imem_req}, 32'h1);
        chk("startup_addr", o_imem_addr,         32'h0);

        tick(5);
        chk("stream_instr", o_instr,     32'd16);
        chk("stream_pc",    o_pc,        32'd24);
        chk("stream_addr",  o_imem_addr, 32'd20);
        i_stall = 1'b1;

        tick(1);
        chk("stall_req_drop", {31'b0, o_imem_req},          32'h0);
        chk("stall_hold",     o_instr,                      32'd16);
        chk("stall_skb_full", {31'b0, dut.u_skid.skb_full_q}, 32'h1);

        tick(2);
        chk("stall_hold_late", o_instr,                    32'd16);
        chk("stall_valid",     {31'b0, o_instr_valid},     32'h1);
        i_stall = 1'b0;

        tick(4);
        chk("resume_addr", o_imem_addr, 32'd36);
        i_imem_ack = 1'b0;

        // Branch with a request outstanding and a late ack.
        tick(1);
        chk("pre_branch_valid", {31'b0, o_instr_valid}, 32'h0);
        i_branch_en     = 1'b1;
        i_branch_target = 32'h0000_0100;

        tick(1);
        i_branch_en = 1'b0;
        chk("flush_req",   {31'b0, o_imem_req},    32'h1);
        chk("flush_addr",  o_imem_addr,            32'd36);
        chk("flush_valid", {31'b0, o_instr_valid}, 32'h0);

        tick(1);
        chk("flush_addr_held", o_imem_addr, 32'd36);
        i_imem_ack = 1'b1;

        tick(1);
        chk("target_addr",  o_imem_addr,            32'h100);
        chk("target_req",   {31'b0, o_imem_req},    32'h1);
        chk("target_valid", {31'b0, o_instr_valid}, 32'h0);

        tick(1);
        chk("target_first_valid", {31'b0, o_instr_valid}, 32'h1);
        chk("target_first_pc",    o_pc,                   32'h108);
        chk("target_first_instr", o_instr,                32'h100);

        // Branch coinciding with ack and stall; OUT word 0x100 is discarded.
        i_stall         = 1'b1;
        i_branch_en     = 1'b1;
        i_branch_target = 32'h0000_0203;

        tick(1);
        i_stall     = 1'b0;
        i_branch_en = 1'b0;
        chk("coinc_valid",    {31'b0, o_instr_valid},          32'h0);
        chk("coinc_skb",      {31'b0, dut.u_skid.skb_full_q},  32'h0);
        chk("coinc_addr",     o_imem_addr,                     32'h200);
        push(32'h200, 32'h208);

        // Wrap: branch to the last word of the address space.
        tick(1);
        chk("post_coinc_addr", o_imem_addr, 32'h204);
        i_branch_en     = 1'b1;
        i_branch_target = 32'hFFFF_FFFC;
        push(32'hFFFF_FFFC, 32'h0000_0004);

        tick(1);
        i_branch_en = 1'b0;
        chk("wrap_start_addr", o_imem_addr, 32'hFFFF_FFFC);

        tick(1);
        chk("wrap_addr", o_imem_addr, 32'h0);
        chk("wrap_pc",   o_pc,        32'h4);
        i_imem_ack = 1'b0;

        // Reset with a request outstanding.
        tick(1);
        chk("midreset_req",  {31'b0, o_imem_req}, 32'h1);
        chk("midreset_addr", o_imem_addr,         32'h0);
        rst = 1'b0;

        tick(1);
        chk_reset_outputs("midreset");

        tick(2);
        chk("scoreboard_drained", exp_q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the register file and decode. Fetch_unit owns the program counter and issues word reads to instruction memory through a req/ack handshake. It presents each fetched instruction together with its architectural PC value (address + 8) to decode and to the register file's PC input. It also absorbs downstream stalls through a one-entry skid buffer and redirects on branches.

## Interface
- RESET_PC, default 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- PC_OFFSET, default 8: added to the instruction address to form o_pc.
- clk  in  1  single clock, all state on posedge.
- rst  in  1  synchronous reset, active-low: state resets on a posedge where rst == 0.
- o_imem_req  out  1  read request to instruction memory.
- o_imem_addr  out  32  word-aligned read address.
- i_imem_ack  in  1  transfer completes in any cycle where o_imem_req && i_imem_ack.
- i_imem_data  in  32  read data, valid with i_imem_ack.
- i_stall  in  1  downstream cannot accept o_instr this cycle.
- i_branch_en  in  1  one-cycle redirect pulse.
- i_branch_target  in  32  redirect address; bits [1:0] are ignored and forced to 0.
- o_instr  out  32  fetched instruction.
- o_instr_valid  out  1  o_instr/o_pc are valid.
- o_pc  out  32  instruction address + PC_OFFSET, mod 2^32; feeds the register file i_pc.

## Operation
- **Storage:**
  - OUT register: o_instr, o_pc, o_instr_valid.
  - SKB register: instr, pc, full.
  - fetch_pc register: drives o_imem_addr.
- **Consume:** consume = o_instr_valid && !i_stall.
- **Completed transfer, no branch:**
  - The data goes to OUT if OUT is empty or is consumed this cycle; otherwise it goes to SKB.
  - fetch_pc advances by 4, wrapping modulo 2^32.
- **Consume with SKB full:** SKB moves to OUT and SKB empties; this has priority over ack data.
- **Issue rule:** a transfer cannot complete into a full SKB, because o_imem_req is low while SKB is full.
- **Address stability:** while o_imem_req is high and no ack has arrived, o_imem_addr is held stable.
- **FSM states:**
  - IDLE: reset state; req = 0.
  - FETCH: req = 1.
  - BLOCKED: SKB full; req = 0.
  - FLUSH: a branch arrived while a request was outstanding.
- **FSM transitions:**
  - IDLE -> FETCH on the first posedge with rst = 1.
  - FETCH -> BLOCKED when an ack is written into SKB.
  - BLOCKED -> FETCH when SKB drains.
  - FETCH -> FLUSH on i_branch_en with the request outstanding and no ack in the same cycle.
  - FLUSH: req stays high with the old address until ack. The ack data is discarded. Then fetch_pc = target and the state goes to FETCH.
- **Branch, highest priority:**
  - Next cycle: o_instr_valid = 0 and SKB full = 0.
  - Any ack data in the branch cycle is discarded.
  - The target is latched into fetch_pc, or into a pending-target register when entering FLUSH.
  - Branch in the same cycle as an ack: go straight to FETCH at the target.
  - Branch in BLOCKED or IDLE: go to FETCH at the target.
  - Branch during FLUSH: the newer target replaces the pending one.
- **Reset mid-transfer:** the outstanding request is abandoned; the memory side must tolerate req dropping.

## Timing
- **Reset values:**
  - o_imem_req = 0, o_imem_addr = RESET_PC.
  - o_instr = 0, o_pc = 0, o_instr_valid = 0.
  - SKB empty, state IDLE.
- **Outputs:** all outputs are registered; there is no combinational path from any input to any output.
- **Start-up:** first req = 1 with addr = RESET_PC in the cycle after the first posedge with rst = 1.
- **Fetch latency:** ack in cycle n gives o_instr_valid in cycle n+1.
- **Throughput:** with zero-wait memory (ack same cycle as req), one instruction per cycle. req stays high and the address advances by 4 each cycle.
- **Branch latency:**
  - Pulse in cycle n gives req at the target in cycle n+1, when no transfer is pending.
  - In FLUSH, req moves to the target in the cycle after the ack.
- **Stall:** OUT holds its value for every cycle i_stall is high; nothing is lost or duplicated.

## Structure
- Shared package core_pkg holds:
  - fetch_state_t enum: IDLE, FETCH, BLOCKED, FLUSH.
  - WORD_W = 32 and INSTR_BYTES = 4.
  - Default RESET_PC and PC_OFFSET constants, shared with decode and the register file.
- Sub-module fetch_skid holds the OUT/SKB two-entry buffer with its load/consume logic. The FSM and fetch_pc stay in fetch_unit.

## Test plan
- **Reset and start-up:** hold rst = 0 for 3 cycles, then release. During reset all outputs are at reset values. The cycle after release: req = 1, addr = 0.
- **Zero-wait stream:** ack tied to 1, data = address. Every cycle: o_instr = 0, 4, 8, … with o_pc = o_instr + 8.
- **Stall:** stall for 3 cycles during the stream. OUT holds, SKB captures one word, req drops. After release the words continue in order with none lost or duplicated.
- **Branch with wait states:** ack 2 cycles late, branch to 32'h100 while a request is outstanding. Enter FLUSH, the late data is discarded, the next req has addr = 32'h100, and the first valid o_pc = 32'h108.
- **Branch coinciding with ack and stall:** branch to 32'h203 (forced to 32'h200). o_instr_valid = 0 next cycle, SKB is empty, next addr = 32'h200.
- **Wrap and mid-operation reset:** start fetch_pc at 32'hFFFF_FFFC; the next address is 0. Assert rst mid-request; req falls and all outputs return to reset values.
